// File: rtl/quad_encoder_emulator.sv
// quad_encoder_emulator: turns signed relative move commands into Gray-coded
// A/B quadrature edges spaced by a programmable clock divider. It also tracks
// the emitted position, with optional CPR wrap.
// Optional index output: define QUAD_EMU_INDEX_EN to build the registered
// index pulse I. Without the macro, I is tied low.
// Direction convention: CW steps 00->01->11->10->00 on {A,B}. A decoder reads
// posedge A while B=1 as a CW count.
module quad_encoder_emulator #(
    parameter int unsigned buswidth       = 32,
    parameter int unsigned divwidth       = 16,
    parameter int unsigned default_period = 16
) (
    input  logic                Clk,
    input  logic                Reset,
    input  logic [buswidth-1:0] DataBus,
    input  logic                SetCPR,
    input  logic                SetPosition,
    input  logic                SetPeriod,
    input  logic                Move,
    input  logic                Stop,
    output logic                A,
    output logic                B,
    output logic                I,
    output logic [buswidth-1:0] Position,
    output logic                Busy,
    output logic                Direction
);

    localparam logic [buswidth-1:0] BUS_ONE     = buswidth'(1);
    localparam logic [divwidth-1:0] DIV_ONE     = divwidth'(1);
    localparam logic [divwidth-1:0] PERIOD_INIT = divwidth'(default_period);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic                a_q, a_d;
    logic                b_q, b_d;
    logic                busy_q, busy_d;
    logic                dir_q, dir_d;
    logic [buswidth-1:0] pos_q, pos_d;
    logic [buswidth-1:0] cpr_q, cpr_d;
    logic [buswidth-1:0] rem_q, rem_d;
    logic [divwidth-1:0] period_q, period_d;
    logic [divwidth-1:0] div_q, div_d;

    logic [buswidth-1:0] move_mag;
    logic [divwidth-1:0] div_limit;
    logic                step_due;
    logic [buswidth-1:0] step_pos;
    logic                step_a;
    logic                step_b;

    // Magnitude of the signed move count. The most negative value maps to 2^(buswidth-1).
    always_comb begin
        move_mag = DataBus;
        if (DataBus[buswidth-1]) begin
            move_mag = (~DataBus) + BUS_ONE;
        end
    end

    // Divider compare point. A period of zero behaves as one clock per edge.
    always_comb begin
        div_limit = '0;
        if (period_q != '0) begin
            div_limit = period_q - DIV_ONE;
        end
        // >= so that a period shortened mid-count still fires at the next compare
        step_due = (div_q >= div_limit);
    end

    // Next phase and next position for one step in the current direction
    always_comb begin
        step_pos = pos_q;
        if (dir_q) begin
            step_a = b_q;
            step_b = ~a_q;
            if (cpr_q == '0) begin
                step_pos = pos_q + BUS_ONE;
            end else if (pos_q >= (cpr_q - BUS_ONE)) begin
                step_pos = '0;
            end else begin
                step_pos = pos_q + BUS_ONE;
            end
        end else begin
            step_a = ~b_q;
            step_b = a_q;
            if (cpr_q == '0) begin
                step_pos = pos_q - BUS_ONE;
            end else if ((pos_q == '0) || (pos_q >= cpr_q)) begin
                step_pos = cpr_q - BUS_ONE;
            end else begin
                step_pos = pos_q - BUS_ONE;
            end
        end
    end

    // Next-state logic: strobes, move control and edge emission
    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        dir_d    = dir_q;
        pos_d    = pos_q;
        cpr_d    = cpr_q;
        rem_d    = rem_q;
        period_d = period_q;
        div_d    = div_q;

        if (SetCPR) begin
            cpr_d = DataBus;
        end
        if (SetPeriod) begin
            period_d = DataBus[divwidth-1:0];
        end

        if (Stop) begin
            // Stop wins over a simultaneous Move; the A/B levels are frozen
            state_d = ST_IDLE;
            rem_d   = '0;
            div_d   = '0;
        end else if (Move) begin
            // A new move replaces any move in progress; zero magnitude just idles
            dir_d   = ~DataBus[buswidth-1];
            rem_d   = move_mag;
            div_d   = '0;
            state_d = (move_mag != '0) ? ST_RUN : ST_IDLE;
        end else if (state_q == ST_RUN) begin
            if (step_due) begin
                a_d   = step_a;
                b_d   = step_b;
                pos_d = step_pos;
                rem_d = rem_q - BUS_ONE;
                div_d = '0;
                if (rem_q == BUS_ONE) begin
                    state_d = ST_IDLE;
                end
            end else begin
                div_d = div_q + DIV_ONE;
            end
        end

        // A re-base overrides the step's count, but the step's edge still goes out
        if (SetPosition) begin
            pos_d = DataBus;
        end

        busy_d = (state_d == ST_RUN);
    end

    // State and output registers
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q  <= ST_IDLE;
            a_q      <= 1'b0;
            b_q      <= 1'b0;
            busy_q   <= 1'b0;
            dir_q    <= 1'b1;
            pos_q    <= '0;
            cpr_q    <= '0;
            rem_q    <= '0;
            period_q <= PERIOD_INIT;
            div_q    <= '0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            busy_q   <= busy_d;
            dir_q    <= dir_d;
            pos_q    <= pos_d;
            cpr_q    <= cpr_d;
            rem_q    <= rem_d;
            period_q <= period_d;
            div_q    <= div_d;
        end
    end

`ifdef QUAD_EMU_INDEX_EN
    logic i_q, i_d;

    // Index marks the zero count at phase 00 once per revolution, aligned with Position
    always_comb begin
        i_d = (cpr_d != '0) && (pos_d == '0) && (a_d == 1'b0) && (b_d == 1'b0);
    end

    // Index register
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            i_q <= 1'b0;
        end else begin
            i_q <= i_d;
        end
    end

    assign I = i_q;
`else
    assign I = 1'b0;
`endif

    assign A         = a_q;
    assign B         = b_q;
    assign Position  = pos_q;
    assign Busy      = busy_q;
    assign Direction = dir_q;

endmodule

// File: tb/tb_quad_encoder_emulator.sv
// Self-checking bench for quad_encoder_emulator against a cycle-level
// behavioural model of the move/edge/position rules.
module tb_quad_encoder_emulator;

    logic        Clk;
    logic        Reset;
    logic [31:0] DataBus;
    logic        SetCPR, SetPosition, SetPeriod, Move, Stop;
    logic        A, B, I, Busy, Direction;
    logic [31:0] Position;

    int vecs  = 0;
    int fails = 0;

    quad_encoder_emulator dut (
        .Clk(Clk), .Reset(Reset), .DataBus(DataBus),
        .SetCPR(SetCPR), .SetPosition(SetPosition), .SetPeriod(SetPeriod),
        .Move(Move), .Stop(Stop),
        .A(A), .B(B), .I(I), .Position(Position), .Busy(Busy), .Direction(Direction)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Reference model state: phase is an index into the CW Gray sequence
    logic [1:0]  gray [4] = '{2'b00, 2'b01, 2'b11, 2'b10};
    int          m_phase;
    logic [31:0] m_pos, m_cpr, m_rem;
    bit          m_dir, m_busy;
    int          m_period, m_elapsed;

    function automatic void model_reset();
        m_phase = 0; m_pos = 0; m_cpr = 0; m_rem = 0;
        m_dir = 1'b1; m_busy = 1'b0; m_period = 16; m_elapsed = 0;
    endfunction

    function automatic void model_clk();
        longint unsigned p, c, mag;
        int eff;
        if (Stop) begin
            m_busy = 1'b0; m_rem = 0; m_elapsed = 0;
        end else if (Move) begin
            m_dir = !DataBus[31];
            mag = DataBus[31] ? (64'd4294967296 - {32'd0, DataBus}) : {32'd0, DataBus};
            m_rem = 32'(mag);
            m_busy = (mag != 0);
            m_elapsed = 0;
        end else if (m_busy) begin
            eff = (m_period == 0) ? 1 : m_period;
            m_elapsed++;
            if (m_elapsed >= eff) begin
                m_elapsed = 0;
                m_phase = m_dir ? (m_phase + 1) % 4 : (m_phase + 3) % 4;
                p = {32'd0, m_pos};
                c = {32'd0, m_cpr};
                if (c == 0) p = m_dir ? p + 1 : p + 64'hFFFF_FFFF;
                else if (m_dir) p = (p + 1 >= c) ? 0 : p + 1;
                else p = (p == 0 || p >= c) ? c - 1 : p - 1;
                m_pos = 32'(p);
                m_rem = m_rem - 1;
                if (m_rem == 0) m_busy = 1'b0;
            end
        end
        if (SetPosition) m_pos = DataBus;
        if (SetCPR) m_cpr = DataBus;
        if (SetPeriod) m_period = int'(DataBus[15:0]);
    endfunction

    function automatic logic [36:0] exp_vec();
        logic [1:0] ab;
        logic       idx;
        ab = gray[m_phase];
`ifdef QUAD_EMU_INDEX_EN
        idx = (m_cpr != 0) && (m_pos == 0) && (m_phase == 0);
`else
        idx = 1'b0;
`endif
        return {ab, idx, m_busy, m_dir, m_pos};
    endfunction

    // One clock with the given strobes; leaves time at posedge+1 with strobes cleared
    task automatic cyc(input bit mv, input bit st, input bit sp, input bit sc,
                       input bit sper, input logic [31:0] d);
        Move = mv; Stop = st; SetPosition = sp; SetCPR = sc; SetPeriod = sper; DataBus = d;
        @(posedge Clk);
        if (Reset) model_reset(); else model_clk();
        #1;
        Move = 0; Stop = 0; SetPosition = 0; SetCPR = 0; SetPeriod = 0; DataBus = 32'h0;
    endtask

    task automatic do_reset();
        #3 Reset = 1'b1;
        @(posedge Clk);
        model_reset();
        #3 Reset = 1'b0;
    endtask

    task automatic test_reset();
        Reset = 1'b0;
        #2 Reset = 1'b1;
        model_reset();
        #1;
        if ({A, B, I, Busy, Direction, Position} !== {5'b00001, 32'h0}) begin
            fails++;
            $display("FAIL reset_values got=%h exp=%h", {A, B, I, Busy, Direction, Position}, {5'b00001, 32'h0});
        end
        vecs++;
        @(posedge Clk);
        #3 Reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            cyc(0, 0, 0, 0, 0, 32'h0);
            if ({A, B, I, Busy, Direction, Position} !== exp_vec()) begin
                fails++;
                $display("FAIL reset_idle got=%h exp=%h", {A, B, I, Busy, Direction, Position}, exp_vec());
            end
            vecs++;
        end
    endtask

    task automatic test_forward();
        int edges[$];
        logic [1:0] prev;
        do_reset();
        cyc(0, 0, 0, 0, 1, 32'd4);
        cyc(1, 0, 0, 0, 0, 32'd5);
        prev = {A, B};
        for (int c = 1; c <= 28; c++) begin
            cyc(0, 0, 0, 0, 0, 32'h0);
            if ({A, B} != prev) edges.push_back(c);
            prev = {A, B};
            if ({A, B, I, Busy, Direction, Position} !== exp_vec()) begin
                fails++;
                $display("FAIL fwd_cycle c=%0d got=%h exp=%h", c, {A, B, I, Busy, Direction, Position}, exp_vec());
            end
            vecs++;
        end
        if (edges.size() != 5) begin
            fails++;
            $display("FAIL fwd_edge_count got=%0d exp=5", edges.size());
        end else begin
            for (int k = 0; k < 5; k++) begin
                if (edges[k] != 4 * (k + 1)) begin
                    fails++;
                    $display("FAIL fwd_edge_time k=%0d got=%0d exp=%0d", k, edges[k], 4 * (k + 1));
                end
            end
        end
        vecs++;
        if (Position !== 32'd5 || Direction !== 1'b1 || Busy !== 1'b0) begin
            fails++;
            $display("FAIL fwd_final pos=%0d dir=%b busy=%b exp 5/1/0", Position, Direction, Busy);
        end
        vecs++;
    endtask

    task automatic test_reverse();
        logic [1:0] seq [3] = '{2'b10, 2'b11, 2'b01};
        do_reset();
        cyc(0, 0, 0, 0, 1, 32'd1);
        cyc(1, 0, 0, 0, 0, 32'hFFFF_FFFD);
        for (int k = 0; k < 3; k++) begin
            cyc(0, 0, 0, 0, 0, 32'h0);
            if ({A, B} !== seq[k] || {A, B, I, Busy, Direction, Position} !== exp_vec()) begin
                fails++;
                $display("FAIL rev_step k=%0d got=%h exp=%h", k, {A, B, I, Busy, Direction, Position}, exp_vec());
            end
            vecs++;
        end
        if (Position !== 32'hFFFF_FFFD || Direction !== 1'b0) begin
            fails++;
            $display("FAIL rev_final pos=%h dir=%b exp FFFFFFFD/0", Position, Direction);
        end
        vecs++;
    endtask

    task automatic test_cpr_wrap();
        logic [31:0] want [3] = '{32'd7, 32'd0, 32'd1};
        int n = 0;
        logic [31:0] prev;
        do_reset();
        cyc(0, 0, 0, 1, 0, 32'd8);
        cyc(0, 0, 1, 0, 0, 32'd6);
        cyc(0, 0, 0, 0, 1, 32'd2);
        cyc(1, 0, 0, 0, 0, 32'd3);
        prev = Position;
        for (int c = 0; c < 10; c++) begin
            cyc(0, 0, 0, 0, 0, 32'h0);
            if (Position != prev && n < 3) begin
                if (Position !== want[n]) begin
                    fails++;
                    $display("FAIL cpr_seq n=%0d got=%0d exp=%0d", n, Position, want[n]);
                end
                vecs++;
                n++;
            end
            prev = Position;
            if ({A, B, I, Busy, Direction, Position} !== exp_vec()) begin
                fails++;
                $display("FAIL cpr_cycle c=%0d got=%h exp=%h", c, {A, B, I, Busy, Direction, Position}, exp_vec());
            end
            vecs++;
        end
        // CCW wrap from 0 back to CPR-1
        cyc(1, 0, 0, 0, 0, 32'hFFFF_FFFE);
        for (int c = 0; c < 6; c++) begin
            cyc(0, 0, 0, 0, 0, 32'h0);
            if ({A, B, I, Busy, Direction, Position} !== exp_vec()) begin
                fails++;
                $display("FAIL cpr_ccw c=%0d got=%h exp=%h", c, {A, B, I, Busy, Direction, Position}, exp_vec());
            end
            vecs++;
        end
        if (Position !== 32'd7) begin
            fails++;
            $display("FAIL cpr_ccw_final got=%0d exp=7", Position);
        end
        vecs++;
    endtask

    task automatic test_stop();
        int guard = 0;
        logic [1:0] frozen;
        do_reset();
        cyc(0, 0, 0, 0, 1, 32'd3);
        cyc(1, 0, 0, 0, 0, 32'd100);
        while (m_pos != 32'd10 && guard < 200) begin
            cyc(0, 0, 0, 0, 0, 32'h0);
            guard++;
        end
        if (guard >= 200) begin
            fails++;
            $display("FAIL stop_wait timeout got=%0d exp=10", m_pos);
        end
        vecs++;
        cyc(0, 1, 0, 0, 0, 32'h0);
        frozen = {A, B};
        if (Busy !== 1'b0 || Position !== 32'd10) begin
            fails++;
            $display("FAIL stop_state busy=%b pos=%0d exp 0/10", Busy, Position);
        end
        vecs++;
        for (int c = 0; c < 50; c++) begin
            cyc(0, 0, 0, 0, 0, 32'h0);
            if ({A, B} !== frozen || {A, B, I, Busy, Direction, Position} !== exp_vec()) begin
                fails++;
                $display("FAIL stop_hold c=%0d got=%h exp=%h", c, {A, B, I, Busy, Direction, Position}, exp_vec());
            end
            vecs++;
        end
        cyc(1, 1, 0, 0, 0, 32'd7);
        for (int c = 0; c < 8; c++) begin
            if (Busy !== 1'b0 || {A, B, I, Busy, Direction, Position} !== exp_vec()) begin
                fails++;
                $display("FAIL stop_beats_move c=%0d got=%h exp=%h", c, {A, B, I, Busy, Direction, Position}, exp_vec());
            end
            vecs++;
            cyc(0, 0, 0, 0, 0, 32'h0);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        cyc(0, 0, 0, 0, 1, 32'd2);
        cyc(1, 0, 0, 0, 0, 32'd20);
        for (int c = 0; c < 15; c++) cyc(0, 0, 0, 0, 0, 32'h0);
        if (Position !== 32'd7 || Busy !== 1'b1) begin
            fails++;
            $display("FAIL arst_premove pos=%0d busy=%b exp 7/1", Position, Busy);
        end
        vecs++;
        #3 Reset = 1'b1;
        #1;
        if ({A, B, I, Busy, Direction, Position} !== {5'b00001, 32'h0}) begin
            fails++;
            $display("FAIL arst_immediate got=%h exp=%h", {A, B, I, Busy, Direction, Position}, {5'b00001, 32'h0});
        end
        vecs++;
        model_reset();
        @(posedge Clk);
        #3 Reset = 1'b0;
        for (int c = 0; c < 20; c++) begin
            cyc(0, 0, 0, 0, 0, 32'h0);
            if ({A, B, I, Busy, Direction, Position} !== exp_vec()) begin
                fails++;
                $display("FAIL arst_release c=%0d got=%h exp=%h", c, {A, B, I, Busy, Direction, Position}, exp_vec());
            end
            vecs++;
        end
    endtask

    task automatic test_zero_period();
        int busy_cycles = 0;
        do_reset();
        cyc(0, 0, 0, 0, 1, 32'hABCD_0000);
        cyc(1, 0, 0, 0, 0, 32'd4);
        for (int c = 0; c < 8; c++) begin
            if (Busy === 1'b1) busy_cycles++;
            if ({A, B, I, Busy, Direction, Position} !== exp_vec()) begin
                fails++;
                $display("FAIL p0_cycle c=%0d got=%h exp=%h", c, {A, B, I, Busy, Direction, Position}, exp_vec());
            end
            vecs++;
            cyc(0, 0, 0, 0, 0, 32'h0);
        end
        if (busy_cycles != 4 || Position !== 32'd4) begin
            fails++;
            $display("FAIL p0_busy_len got=%0d pos=%0d exp 4/4", busy_cycles, Position);
        end
        vecs++;
        cyc(0, 0, 0, 0, 1, 32'd5);
        cyc(1, 0, 0, 0, 0, 32'd10);
        cyc(0, 0, 0, 0, 0, 32'h0);
        cyc(1, 0, 0, 0, 0, 32'd0);
        if (Busy !== 1'b0 || {A, B, I, Busy, Direction, Position} !== exp_vec()) begin
            fails++;
            $display("FAIL move_zero got=%h exp=%h", {A, B, I, Busy, Direction, Position}, exp_vec());
        end
        vecs++;
    endtask

    task automatic test_random();
        bit mv, st, sp, sc, sper;
        logic [31:0] d;
        int v;
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            mv   = ($urandom_range(0, 99) < 4);
            st   = ($urandom_range(0, 99) < 2);
            sp   = ($urandom_range(0, 99) < 3);
            sc   = ($urandom_range(0, 99) < 2);
            sper = ($urandom_range(0, 99) < 3);
            if (sper) d = {16'($urandom), 16'($urandom_range(0, 4))};
            else if (mv) begin
                v = int'($urandom_range(0, 24)) - 12;
                d = ($urandom_range(0, 49) == 0) ? 32'h8000_0000 : 32'(v);
            end else if (sc) d = 32'($urandom_range(0, 10));
            else if (sp) d = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 15));
            else d = $urandom;
            cyc(mv, st, sp, sc, sper, d);
            if ({A, B, I, Busy, Direction, Position} !== exp_vec()) begin
                fails++;
                $display("FAIL rand c=%0d got=%h exp=%h", c, {A, B, I, Busy, Direction, Position}, exp_vec());
            end
            vecs++;
        end
    endtask

    initial begin
        Move = 0; Stop = 0; SetPosition = 0; SetCPR = 0; SetPeriod = 0; DataBus = 32'h0;
        test_reset();
        test_forward();
        test_reverse();
        test_cpr_wrap();
        test_stop();
        test_async_reset();
        test_zero_period();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
        $finish;
    end

endmodule
